// File: rtl/axi_if_ct_rd_sched.sv
// rtl/axi_if_ct_rd_sched.sv - CT read scheduler: round-robin grant, page-safe AR burst split, in-order R routing (optional AXI_IF_CT_RD_SCHED_RRESP_CHECK_EN)
module axi_if_ct_rd_sched #(
    parameter int NB_REQ          = 4,
    parameter int ORD_DEPTH       = 8,
    parameter int CMD_WORD_W      = 16,
    parameter int AXI4_ADD_W      = 32,
    parameter int AXI4_DATA_W     = 512,
    parameter int AXI4_ID_W       = 4,
    parameter int AXI4_LEN_MAX    = 256,
    parameter int AXI4_WORD_MAX   = 64,
    parameter int AXI4_DATA_BYTES = AXI4_DATA_W / 8,
    parameter int PAGE_BYTES      = 4096
) (
    input  logic                             clk,
    input  logic                             s_rst,
    input  logic [NB_REQ-1:0]                req_vld,
    output logic [NB_REQ-1:0]                req_rdy,
    input  logic [NB_REQ*AXI4_ADD_W-1:0]     req_add,
    input  logic [NB_REQ*CMD_WORD_W-1:0]     req_word_nb,
    output logic [AXI4_ID_W-1:0]             m_axi4_arid,
    output logic [AXI4_ADD_W-1:0]            m_axi4_araddr,
    output logic [7:0]                       m_axi4_arlen,
    output logic [2:0]                       m_axi4_arsize,
    output logic [1:0]                       m_axi4_arburst,
    output logic                             m_axi4_arvalid,
    input  logic                             m_axi4_arready,
    input  logic [AXI4_DATA_W-1:0]           m_axi4_rdata,
    input  logic [1:0]                       m_axi4_rresp,
    input  logic                             m_axi4_rlast,
    input  logic                             m_axi4_rvalid,
    output logic                             m_axi4_rready,
    output logic [AXI4_DATA_W-1:0]           rsp_data,
    output logic [NB_REQ-1:0]                rsp_vld,
    input  logic [NB_REQ-1:0]                rsp_rdy,
    output logic                             rsp_last,
    output logic                             err
);

    localparam int OW       = $clog2(NB_REQ);
    localparam int OAW      = $clog2(ORD_DEPTH);
    localparam int CW       = OAW + 1;
    localparam int SZ       = $clog2(AXI4_DATA_BYTES);
    localparam int PGW      = $clog2(PAGE_BYTES);
    localparam int PGW1     = PGW + 1;
    localparam int WORD_CAP = (AXI4_WORD_MAX < AXI4_LEN_MAX) ? AXI4_WORD_MAX : AXI4_LEN_MAX;

    typedef enum logic [1:0] {ST_IDLE, ST_SPLIT, ST_ISSUE} state_t;

    state_t                  state, state_nxt;
    logic [OW-1:0]           rr_ptr, gnt_idx, owner_q;
    logic                    gnt_found, accept;
    logic [AXI4_ADD_W-1:0]   sel_add, add_q, araddr_q;
    logic [CMD_WORD_W-1:0]   sel_wn, rem_q, blen_c, blen_q;
    logic [PGW1-1:0]         pg_left;
    logic [31:0]             blen32;
    logic                    arvalid_q, ar_hs, last_burst, push, pop;
    logic [7:0]              arlen_q;

    logic [OW-1:0]           ord_owner [ORD_DEPTH];
    logic                    ord_last  [ORD_DEPTH];
    logic [OAW-1:0]          ord_wr, ord_rd;
    logic [CW-1:0]           ord_cnt;
    logic                    ord_full, ord_empty;
    logic [OW-1:0]           head_owner;

    // Round-robin pick: first valid requester at or after rr_ptr, then wrap around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_add   = '0;
        sel_wn    = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (!gnt_found && req_vld[i] && (OW'(i) >= rr_ptr)) begin
                gnt_found = 1'b1;
                gnt_idx   = OW'(i);
            end
        end
        for (int i = 0; i < NB_REQ; i++) begin
            if (!gnt_found && req_vld[i] && (OW'(i) < rr_ptr)) begin
                gnt_found = 1'b1;
                gnt_idx   = OW'(i);
            end
        end
        for (int i = 0; i < NB_REQ; i++) begin
            if (OW'(i) == gnt_idx) begin
                sel_add = req_add[i*AXI4_ADD_W +: AXI4_ADD_W];
                sel_wn  = req_word_nb[i*CMD_WORD_W +: CMD_WORD_W];
            end
        end
    end

    // Burst length: bounded by remaining words, the AXI4 beat cap and the distance to the page end
    always_comb begin
        pg_left = PGW1'(PAGE_BYTES) - {1'b0, add_q[PGW-1:0]};
        blen32  = 32'(rem_q);
        if (blen32 > 32'(WORD_CAP)) blen32 = 32'(WORD_CAP);
        if (blen32 > 32'(pg_left >> SZ)) blen32 = 32'(pg_left >> SZ);
        blen_c  = CMD_WORD_W'(blen32);
    end

    assign ar_hs      = arvalid_q & m_axi4_arready;
    assign last_burst = (rem_q == blen_q);
    assign push       = ar_hs;

    // FSM state register
    always_ff @(posedge clk) begin
        if (s_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and grant strobe
    always_comb begin
        state_nxt = state;
        req_rdy   = '0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_found && !s_rst) begin
                    req_rdy[gnt_idx] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = ST_SPLIT;
                end
            end
            ST_SPLIT: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (ar_hs) state_nxt = last_burst ? ST_IDLE : ST_SPLIT;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, burst payload registration and arvalid hold-until-handshake
    always_ff @(posedge clk) begin
        if (s_rst) begin
            rr_ptr    <= '0;
            owner_q   <= '0;
            add_q     <= '0;
            rem_q     <= '0;
            blen_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
        end else begin
            if (accept) begin
                add_q   <= sel_add;
                rem_q   <= sel_wn;
                owner_q <= gnt_idx;
                rr_ptr  <= (gnt_idx == OW'(NB_REQ - 1)) ? '0 : gnt_idx + OW'(1);
            end
            if (state == ST_SPLIT) begin
                blen_q   <= blen_c;
                araddr_q <= add_q;
                arlen_q  <= 8'(blen_c - CMD_WORD_W'(1));
                if (!ord_full) arvalid_q <= 1'b1;
            end
            if (state == ST_ISSUE) begin
                if (ar_hs) begin
                    arvalid_q <= 1'b0;
                    rem_q     <= rem_q - blen_q;
                    add_q     <= add_q + (AXI4_ADD_W'(blen_q) << SZ);
                end else if (!arvalid_q && !ord_full) begin
                    arvalid_q <= 1'b1;
                end
            end
        end
    end

    assign m_axi4_arvalid = arvalid_q;
    assign m_axi4_araddr  = araddr_q;
    assign m_axi4_arlen   = arlen_q;
    assign m_axi4_arsize  = 3'(SZ);
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arid    = '0;

    assign ord_full   = (ord_cnt == CW'(ORD_DEPTH));
    assign ord_empty  = (ord_cnt == '0);
    assign head_owner = ord_owner[ord_rd];

    // Order FIFO storage: one entry per issued burst
    always_ff @(posedge clk) begin
        if (push) begin
            ord_owner[ord_wr] <= owner_q;
            ord_last[ord_wr]  <= last_burst;
        end
    end

    // Order FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (s_rst) begin
            ord_wr  <= '0;
            ord_rd  <= '0;
            ord_cnt <= '0;
        end else begin
            if (push) ord_wr <= ord_wr + OAW'(1);
            if (pop)  ord_rd <= ord_rd + OAW'(1);
            case ({push, pop})
                2'b10:   ord_cnt <= ord_cnt + CW'(1);
                2'b01:   ord_cnt <= ord_cnt - CW'(1);
                default: ord_cnt <= ord_cnt;
            endcase
        end
    end

    // R path: steer beats to the owner of the oldest outstanding burst
    always_comb begin
        rsp_vld = '0;
        if (m_axi4_rvalid && !ord_empty) rsp_vld[head_owner] = 1'b1;
    end

    assign m_axi4_rready = !ord_empty & rsp_rdy[head_owner];
    assign rsp_data      = m_axi4_rdata;
    assign rsp_last      = m_axi4_rlast & ord_last[ord_rd];
    assign pop           = m_axi4_rvalid & m_axi4_rready & m_axi4_rlast;

`ifdef AXI_IF_CT_RD_SCHED_RRESP_CHECK_EN
    // Sticky error on any accepted beat with a non-OKAY response
    always_ff @(posedge clk) begin
        if (s_rst)                                                     err <= 1'b0;
        else if (m_axi4_rvalid && m_axi4_rready && m_axi4_rresp != 2'b00) err <= 1'b1;
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi4_rresp;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_axi_if_ct_rd_sched.sv
// tb/tb_axi_if_ct_rd_sched.sv - directed table-driven bench for axi_if_ct_rd_sched
module tb_axi_if_ct_rd_sched;

    localparam int NB_REQ = 4;
    localparam int AW     = 32;
    localparam int DW     = 512;
    localparam int WW     = 16;

    logic                 clk = 1'b0;
    logic                 s_rst;
    logic [NB_REQ-1:0]    req_vld;
    logic [NB_REQ-1:0]    req_rdy;
    logic [NB_REQ*AW-1:0] req_add;
    logic [NB_REQ*WW-1:0] req_word_nb;
    logic [3:0]           m_axi4_arid;
    logic [AW-1:0]        m_axi4_araddr;
    logic [7:0]           m_axi4_arlen;
    logic [2:0]           m_axi4_arsize;
    logic [1:0]           m_axi4_arburst;
    logic                 m_axi4_arvalid;
    logic                 m_axi4_arready;
    logic [DW-1:0]        m_axi4_rdata;
    logic [1:0]           m_axi4_rresp;
    logic                 m_axi4_rlast;
    logic                 m_axi4_rvalid;
    logic                 m_axi4_rready;
    logic [DW-1:0]        rsp_data;
    logic [NB_REQ-1:0]    rsp_vld;
    logic [NB_REQ-1:0]    rsp_rdy;
    logic                 rsp_last;
    logic                 err;

    axi_if_ct_rd_sched #(
        .NB_REQ(NB_REQ), .ORD_DEPTH(2), .CMD_WORD_W(WW), .AXI4_ADD_W(AW),
        .AXI4_DATA_W(DW), .AXI4_ID_W(4), .AXI4_LEN_MAX(256), .AXI4_WORD_MAX(64),
        .AXI4_DATA_BYTES(64), .PAGE_BYTES(4096)
    ) dut (
        .clk(clk), .s_rst(s_rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_add(req_add), .req_word_nb(req_word_nb),
        .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arlen(m_axi4_arlen),
        .m_axi4_arsize(m_axi4_arsize), .m_axi4_arburst(m_axi4_arburst),
        .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
        .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp), .m_axi4_rlast(m_axi4_rlast),
        .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
        .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_last(rsp_last),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              req;
        logic [31:0]     add;
        int              wn;
        int              nb;
        logic [2:0][31:0] ba;
        logic [2:0][7:0]  bl;
    } vec_t;

    vec_t vecs [5];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
`ifdef AXI_IF_CT_RD_SCHED_RRESP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic set_vec(input int i, input int r, input logic [31:0] a, input int wn, input int nb,
                           input logic [31:0] a0, input int l0, input logic [31:0] a1, input int l1,
                           input logic [31:0] a2, input int l2);
        vecs[i].req = r;  vecs[i].add = a;  vecs[i].wn = wn;  vecs[i].nb = nb;
        vecs[i].ba[0] = a0; vecs[i].bl[0] = 8'(l0);
        vecs[i].ba[1] = a1; vecs[i].bl[1] = 8'(l1);
        vecs[i].ba[2] = a2; vecs[i].bl[2] = 8'(l2);
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        req_vld = '0; req_add = '0; req_word_nb = '0;
        m_axi4_arready = 1'b0; m_axi4_rvalid = 1'b0; m_axi4_rlast = 1'b0;
        m_axi4_rresp = 2'b00; m_axi4_rdata = '0; rsp_rdy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_rst = 1'b0;
    endtask

    // Tasks enter at a negedge and return at a negedge.
    task automatic wait_rdy(input int r);
        int n = 0;
        #1;
        while (req_rdy == '0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", 64'(req_rdy), 64'(1) << r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant(input int r, input logic [31:0] a, input int wn);
        req_add[r*AW +: AW]     = a;
        req_word_nb[r*WW +: WW] = 16'(wn);
        req_vld[r]              = 1'b1;
        wait_rdy(r);
        req_vld[r]              = 1'b0;
    endtask

    task automatic ar_expect(input logic [31:0] a, input int l);
        int n = 0;
        #1;
        while (!m_axi4_arvalid && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("arvalid", 64'(m_axi4_arvalid), 64'(1));
        chk("araddr", 64'(m_axi4_araddr), 64'(a));
        chk("arlen", 64'(m_axi4_arlen), 64'(l));
        chk("arsize", 64'(m_axi4_arsize), 64'(6));
        chk("arburst", 64'(m_axi4_arburst), 64'(1));
        chk("arid", 64'(m_axi4_arid), 64'(0));
        m_axi4_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi4_arready = 1'b0;
    endtask

    task automatic r_burst(input int nb, input int own, input bit cmd_last, input int bad);
        logic [31:0] w;
        for (int b = 0; b < nb; b++) begin
            w             = {own[7:0], 8'h5A, b[15:0]};
            m_axi4_rdata  = {16{w}};
            m_axi4_rvalid = 1'b1;
            m_axi4_rlast  = (b == nb - 1);
            m_axi4_rresp  = (b == bad) ? 2'b10 : 2'b00;
            rsp_rdy       = '1;
            #1;
            chk("rsp_vld", 64'(rsp_vld), 64'(1) << own);
            chk("rready", 64'(m_axi4_rready), 64'(1));
            chk("rsp_last", 64'(rsp_last), 64'((b == nb - 1) && cmd_last));
            chk("rsp_data", rsp_data[63:0], {w, w});
            @(posedge clk);
            @(negedge clk);
        end
        m_axi4_rvalid = 1'b0;
        m_axi4_rlast  = 1'b0;
        m_axi4_rresp  = 2'b00;
    endtask

    task automatic expect_no_ar(input int ncyc);
        int hits = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (m_axi4_arvalid) hits++;
            @(negedge clk);
        end
        chk("no_ar_when_full", 64'(hits), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        set_vec(0, 0, 32'h0,    10,  1, 32'h0,   9,  32'h0,    0,  32'h0,    0);
        set_vec(1, 0, 32'hFC0,  3,   2, 32'hFC0, 0,  32'h1000, 1,  32'h0,    0);
        set_vec(2, 2, 32'h0,    130, 3, 32'h0,   63, 32'h1000, 63, 32'h2000, 1);
        set_vec(3, 3, 32'h1F80, 64,  2, 32'h1F80, 1, 32'h2000, 61, 32'h0,    0);
        set_vec(4, 1, 32'h40,   1,   1, 32'h40,  0,  32'h0,    0,  32'h0,    0);

        // Reset values, with every input pushing against them
        s_rst = 1'b1;
        req_vld = '1; req_add = '0; req_word_nb = '1;
        m_axi4_arready = 1'b1; m_axi4_rvalid = 1'b1; m_axi4_rlast = 1'b1;
        m_axi4_rresp = 2'b10; m_axi4_rdata = '0; rsp_rdy = '1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_arvalid", 64'(m_axi4_arvalid), 64'(0));
        chk("rst_araddr", 64'(m_axi4_araddr), 64'(0));
        chk("rst_arlen", 64'(m_axi4_arlen), 64'(0));
        chk("rst_arsize", 64'(m_axi4_arsize), 64'(6));
        chk("rst_arburst", 64'(m_axi4_arburst), 64'(1));
        chk("rst_arid", 64'(m_axi4_arid), 64'(0));
        chk("rst_req_rdy", 64'(req_rdy), 64'(0));
        chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("rst_rready", 64'(m_axi4_rready), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        do_reset();

        // Table: one command at a time, each burst served right after its AR
        for (int v = 0; v < 5; v++) begin
            wait_grant(vecs[v].req, vecs[v].add, vecs[v].wn);
            for (int k = 0; k < vecs[v].nb; k++) begin
                ar_expect(vecs[v].ba[k], int'(vecs[v].bl[k]));
                r_burst(int'(vecs[v].bl[k]) + 1, vecs[v].req, k == vecs[v].nb - 1, -1);
            end
        end

        // AR backpressure, then R backpressure on the owner
        wait_grant(1, 32'h80, 4);
        #1;
        for (int n = 0; n < 20 && !m_axi4_arvalid; n++) begin @(negedge clk); #1; end
        for (int c = 0; c < 5; c++) begin
            chk("bp_arvalid", 64'(m_axi4_arvalid), 64'(1));
            chk("bp_araddr", 64'(m_axi4_araddr), 64'h80);
            chk("bp_arlen", 64'(m_axi4_arlen), 64'(3));
            @(negedge clk); #1;
        end
        m_axi4_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi4_arready = 1'b0;
        m_axi4_rvalid = 1'b1; m_axi4_rlast = 1'b1; rsp_rdy = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_rready", 64'(m_axi4_rready), 64'(0));
            chk("bp_rsp_vld", 64'(rsp_vld), 64'b0010);
            @(negedge clk);
        end
        r_burst(4, 1, 1'b1, -1);

        // Round-robin with req0/req1 held valid; R returned in issue order
        do_reset();
        req_add[0*AW +: AW] = 32'h100; req_word_nb[0*WW +: WW] = 16'd1;
        req_add[1*AW +: AW] = 32'h200; req_word_nb[1*WW +: WW] = 16'd2;
        req_vld = 4'b0011;
        wait_rdy(0);
        ar_expect(32'h100, 0);
        wait_rdy(1);
        ar_expect(32'h200, 1);
        wait_rdy(0);
        req_vld = '0;
        expect_no_ar(6);
        r_burst(1, 0, 1'b1, -1);
        r_burst(2, 1, 1'b1, -1);
        ar_expect(32'h100, 0);
        r_burst(1, 0, 1'b1, -1);

        // FIFO full stall (depth 2), release on first rlast, sticky error
        wait_grant(0, 32'h0, 192);
        ar_expect(32'h0, 63);
        ar_expect(32'h1000, 63);
        expect_no_ar(10);
        r_burst(64, 0, 1'b0, 5);
        chk("err_set", 64'(err), 64'(ERR_EXP));
        ar_expect(32'h2000, 63);
        r_burst(64, 0, 1'b0, -1);
        r_burst(64, 0, 1'b1, -1);
        chk("err_sticky", 64'(err), 64'(ERR_EXP));
        do_reset();
        #1;
        chk("err_cleared", 64'(err), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
